pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter GROUP, default 8: carry-lookahead group width; WIDTH SHALL be a multiple of GROUP.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; ignored when sub=1.
REQ-011 sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1).
REQ-012 sat  input  1  1 = clamp two's-complement signed overflow.
REQ-013 out_valid  output  1  result beat present.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 sum  output  WIDTH  result.
REQ-016 cout  output  1  unsigned carry-out of MSB (borrow-not when sub=1).
REQ-017 ovf  output  1  signed overflow detected (reported even when clamped).

Function
REQ-018 SHALL split the datapath into S = WIDTH/GROUP stages; stage k computes group k (bits k*GROUP+GROUP-1 .. k*GROUP) with per-bit P = a^b', G = a&b' and lookahead carries inside the group.
REQ-019 SHALL register each group's carry-out into the next stage; operand bits not yet consumed SHALL travel in skew registers; finished sum bits SHALL be carried alongside.
REQ-020 Latency SHALL be exactly S cycles from accepted beat (in_valid & in_ready) to out_valid, absent back-pressure; S=4 at defaults.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-022 Stall: advance = !out_valid | out_ready; in_ready = advance; on !advance every stage register, valid bit and output SHALL hold.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while advancing) SHALL propagate as invalid slots.
REQ-024 sub, sat and cin SHALL be captured with the beat and travel with it; mode changes between beats SHALL not affect in-flight beats.
REQ-025 b' = b ^ {WIDTH{sub}}; effective carry-in = sub ? 1 : cin.
REQ-026 ovf = (a[MSB] == b'[MSB]) & (raw_sum[MSB] != a[MSB]); cout = carry out of final group.
REQ-027 If sat=1 and ovf=1: sum = a[MSB] ? most-negative (1 followed by zeros) : most-positive (0 followed by ones); else sum = raw WIDTH-bit result (wrap-around).
REQ-028 Simultaneous accept and emit in one cycle SHALL be supported with no lost or duplicated beat.
REQ-029 out_valid, sum, cout, ovf SHALL be registered outputs; in_ready is combinational from out_valid and out_ready only.

Reset
REQ-030 On rst_n=0, all valid bits, out_valid, sum, cout, ovf SHALL clear to 0 immediately, regardless of clk.
REQ-031 In-flight beats SHALL be discarded at reset; first beat after rst_n rises SHALL emerge after S cycles.
REQ-032 in_ready SHALL be 1 during and after reset (out_valid=0).

Verification (WIDTH=32, GROUP=8)
REQ-033 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, sat=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0 (carry ripples across all stages).
REQ-034 a=0x7FFFFFFF, b=0x00000001, sat=1 -> sum=0x7FFFFFFF, ovf=1, cout=0; same with sat=0 -> sum=0x80000000, ovf=1.
REQ-035 a=0x80000000, b=0x00000001, sub=1, sat=1 -> sum=0x80000000, ovf=1, cout=1; a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-036 Stream 10 random beats back-to-back with out_ready toggling pseudo-randomly -> results in order, match reference model, none lost/duplicated, outputs stable while out_valid=1 & out_ready=0.
REQ-037 Assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 same cycle; after release, only beats accepted post-reset appear.
REQ-038 Alternate sub=0/1 and sat=0/1 on consecutive beats with bubbles interleaved -> each result uses its own captured mode; bubbles never raise out_valid.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// unconsumed operand bits skew forward, finished sum bits travel alongside.

module cla_group #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout
);
  logic [GROUP-1:0] p, g;
  logic [GROUP:0]   c;
  logic             gg, pp;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a prefix (G, P) of the group bits applied to cin, not a ripple of c[i].
  always_comb begin
    gg   = 1'b0;
    pp   = 1'b1;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      gg       = g[i] | (p[i] & gg);
      pp       = pp & p[i];
      c[i+1]   = gg | (pp & cin);
    end
  end

  assign s    = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
endmodule

module cla_stage #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  parameter int K     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           adv,
  input  logic [WIDTH-K*GROUP-1:0]       a_i,
  input  logic [WIDTH-K*GROUP-1:0]       b_i,
  input  logic [K*GROUP:0]               cd_i,   // {carry, finished sum bits}
  input  logic                           sat_i,
  output logic [WIDTH-(K+1)*GROUP-1:0]   a_o,
  output logic [WIDTH-(K+1)*GROUP-1:0]   b_o,
  output logic [(K+1)*GROUP:0]           cd_o,
  output logic                           sat_o
);
  localparam int R = WIDTH - K*GROUP;
  localparam int D = K*GROUP;

  logic [GROUP-1:0] gs;
  logic             gc;
  logic [D+GROUP:0] cd_nx;

  cla_group #(.GROUP(GROUP)) u_grp (
    .a(a_i[GROUP-1:0]), .b(b_i[GROUP-1:0]), .cin(cd_i[D]), .s(gs), .cout(gc)
  );

  if (K == 0) begin : g_first
    assign cd_nx = {gc, gs};
  end else begin : g_rest
    assign cd_nx = {gc, gs, cd_i[D-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o   <= '0;
      b_o   <= '0;
      cd_o  <= '0;
      sat_o <= 1'b0;
    end else if (adv) begin
      a_o   <= a_i[R-1:GROUP];
      b_o   <= b_i[R-1:GROUP];
      cd_o  <= cd_nx;
      sat_o <= sat_i;
    end
  end
endmodule

module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int S = WIDTH / GROUP;

  // Slot k (1..S-1) is the register set feeding stage k; slots shrink/grow, so they
  // are packed back to back in flat vectors at these offsets.
  function automatic int aoff(input int k);
    return (k-1)*WIDTH - GROUP*(k-1)*k/2;
  endfunction
  function automatic int coff(input int k);
    return GROUP*(k-1)*k/2 + (k-1);
  endfunction

  localparam int AT = (S > 1) ? aoff(S) : 1;
  localparam int CT = (S > 1) ? coff(S) : 1;
  localparam int SW = (S > 1) ? S-1 : 1;

  logic             adv;
  logic [S-1:0]     vld_pipe;
  logic [WIDTH-1:0] bx;
  logic             cx;
  logic [AT-1:0]    a_sk, b_sk;
  logic [CT-1:0]    cd_sk;
  logic [SW-1:0]    sat_sk;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[S-1];
  assign bx        = b ^ {WIDTH{sub}};
  assign cx        = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= (vld_pipe << 1) | S'(in_valid);
  end

  for (genvar k = 0; k < S-1; k++) begin : g_stg
    if (k == 0) begin : g_in
      cla_stage #(.WIDTH(WIDTH), .GROUP(GROUP), .K(0)) u_stg (
        .clk(clk), .rst_n(rst_n), .adv(adv),
        .a_i(a), .b_i(bx), .cd_i(cx), .sat_i(sat),
        .a_o(a_sk[aoff(1) +: WIDTH-GROUP]), .b_o(b_sk[aoff(1) +: WIDTH-GROUP]),
        .cd_o(cd_sk[coff(1) +: GROUP+1]), .sat_o(sat_sk[0])
      );
    end else begin : g_mid
      cla_stage #(.WIDTH(WIDTH), .GROUP(GROUP), .K(k)) u_stg (
        .clk(clk), .rst_n(rst_n), .adv(adv),
        .a_i(a_sk[aoff(k) +: WIDTH-k*GROUP]), .b_i(b_sk[aoff(k) +: WIDTH-k*GROUP]),
        .cd_i(cd_sk[coff(k) +: k*GROUP+1]), .sat_i(sat_sk[k-1]),
        .a_o(a_sk[aoff(k+1) +: WIDTH-(k+1)*GROUP]), .b_o(b_sk[aoff(k+1) +: WIDTH-(k+1)*GROUP]),
        .cd_o(cd_sk[coff(k+1) +: (k+1)*GROUP+1]), .sat_o(sat_sk[k])
      );
    end
  end

  // Final group: completes the raw sum, then overflow detect and clamp into the output regs.
  logic [GROUP-1:0]   la, lb, lgs;
  logic [WIDTH-GROUP:0] lcd;
  logic               lsat, lgc, ovf_nx;
  logic [WIDTH-1:0]   raw, sum_nx;

  if (S == 1) begin : g_one
    assign la   = a;
    assign lb   = bx;
    assign lcd  = cx;
    assign lsat = sat;
    assign raw  = lgs;
  end else begin : g_many
    assign la   = a_sk[aoff(S-1) +: GROUP];
    assign lb   = b_sk[aoff(S-1) +: GROUP];
    assign lcd  = cd_sk[coff(S-1) +: WIDTH-GROUP+1];
    assign lsat = sat_sk[S-2];
    assign raw  = {lgs, lcd[WIDTH-GROUP-1:0]};
  end

  cla_group #(.GROUP(GROUP)) u_last (
    .a(la), .b(lb), .cin(lcd[WIDTH-GROUP]), .s(lgs), .cout(lgc)
  );

  assign ovf_nx = (la[GROUP-1] == lb[GROUP-1]) & (raw[WIDTH-1] != la[GROUP-1]);
  assign sum_nx = (lsat & ovf_nx) ?
                  (la[GROUP-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (adv) begin
      sum  <= sum_nx;
      cout <= lgc;
      ovf  <= ovf_nx;
    end
  end
endmodule
